// File: rtl/scaler_bank.sv
// scaler_bank: NCHAN saturating event counters with a strobe-driven snapshot bank
// streamed out channel-by-channel over valid/ready, plus a missed-snapshot counter.
module scaler_bank #(
   parameter int NCHAN      = 8,
   parameter int WIDTH      = 12,
   parameter int MISS_WIDTH = 8
) (
   input  logic                     ifclk_i,
   input  logic                     rst_n_i,
   input  logic                     enable_i,
   input  logic [NCHAN-1:0]         count_i,
   input  logic                     period_ce_i,
   output logic [WIDTH:0]           dat_o,
   output logic [$clog2(NCHAN)-1:0] chan_o,
   output logic                     valid_o,
   output logic                     last_o,
   input  logic                     ready_i,
   output logic                     busy_o,
   output logic                     missed_o,
   output logic [MISS_WIDTH-1:0]    miss_cnt_o
);

   localparam int CW = $clog2(NCHAN);
   localparam logic [CW-1:0]         LAST_CHAN = CW'(NCHAN - 1);
   localparam logic [WIDTH-1:0]      MAX_CNT   = '1;
   localparam logic [MISS_WIDTH-1:0] MAX_MISS  = '1;

   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          ptr_q, ptr_d;
   logic [WIDTH-1:0]       live_q [NCHAN];
   logic [WIDTH-1:0]       live_d [NCHAN];
   logic [NCHAN-1:0]       sat_q, sat_d;
   logic [WIDTH-1:0]       hold_q [NCHAN];
   logic [NCHAN-1:0]       holdSat_q;
   logic                   loadHold;
   logic                   missed_q, missed_d;
   logic [MISS_WIDTH-1:0]  missCnt_q, missCnt_d;

   // An event coinciding with the strobe belongs to the new period, so it seeds the counter.
   always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
         live_d[c] = live_q[c];
         sat_d[c]  = sat_q[c];
         if (period_ce_i) begin
            live_d[c] = WIDTH'(enable_i & count_i[c]);
            sat_d[c]  = 1'b0;
         end else if (enable_i & count_i[c]) begin
            if (live_q[c] != MAX_CNT) begin
               live_d[c] = live_q[c] + WIDTH'(1);
            end else begin
               sat_d[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      loadHold = 1'b0;
      case (state_q)
         IDLE: begin
            if (period_ce_i) begin
               state_d  = STREAM;
               ptr_d    = '0;
               loadHold = 1'b1;
            end
         end
         STREAM: begin
            if (ready_i) begin
               if (ptr_q == LAST_CHAN) begin
                  state_d = IDLE;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // A strobe while still streaming (including the final-handshake cycle) is a dropped snapshot.
   always_comb begin
      missed_d  = period_ce_i && (state_q == STREAM);
      missCnt_d = missCnt_q;
      if (missed_d && (missCnt_q != MAX_MISS)) begin
         missCnt_d = missCnt_q + MISS_WIDTH'(1);
      end
   end

   always_ff @(posedge ifclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sat_q     <= '0;
         holdSat_q <= '0;
         missed_q  <= 1'b0;
         missCnt_q <= '0;
         for (int c = 0; c < NCHAN; c++) begin
            live_q[c] <= '0;
            hold_q[c] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sat_q     <= sat_d;
         missed_q  <= missed_d;
         missCnt_q <= missCnt_d;
         for (int c = 0; c < NCHAN; c++) begin
            live_q[c] <= live_d[c];
         end
         if (loadHold) begin
            holdSat_q <= sat_q;
            for (int c = 0; c < NCHAN; c++) begin
               hold_q[c] <= live_q[c];
            end
         end
      end
   end

   assign valid_o    = (state_q == STREAM);
   assign busy_o     = (state_q == STREAM);
   assign last_o     = valid_o && (ptr_q == LAST_CHAN);
   assign chan_o     = ptr_q;
   assign dat_o      = valid_o ? {holdSat_q[ptr_q], hold_q[ptr_q]} : '0;
   assign missed_o   = missed_q;
   assign miss_cnt_o = missCnt_q;

endmodule

// File: tb/tb_scaler_bank.sv
// Directed testbench for scaler_bank: a default 12-bit instance and a 4-bit instance
// share the same stimulus; expected words are hand-computed per scenario.
module tb_scaler_bank;

   logic        clk = 1'b0;
   logic        rstN;
   logic        enable;
   logic [7:0]  count;
   logic        periodCe;
   logic        ready;

   logic [12:0] dat;
   logic [2:0]  chan;
   logic        valid, last, busy, missed;
   logic [7:0]  missCnt;

   logic [4:0]  datS;
   logic [2:0]  chanS;
   logic        validS, lastS, busyS, missedS;
   logic [7:0]  missCntS;

   int assertCount = 0;
   int failCount   = 0;

   logic [12:0] expWord  [8];
   logic [4:0]  expWordS [8];

   always #5 clk = ~clk;

   scaler_bank dut (
      .ifclk_i(clk), .rst_n_i(rstN), .enable_i(enable), .count_i(count),
      .period_ce_i(periodCe), .dat_o(dat), .chan_o(chan), .valid_o(valid),
      .last_o(last), .ready_i(ready), .busy_o(busy), .missed_o(missed),
      .miss_cnt_o(missCnt)
   );

   scaler_bank #(.NCHAN(8), .WIDTH(4), .MISS_WIDTH(8)) dutS (
      .ifclk_i(clk), .rst_n_i(rstN), .enable_i(enable), .count_i(count),
      .period_ce_i(periodCe), .dat_o(datS), .chan_o(chanS), .valid_o(validS),
      .last_o(lastS), .ready_i(ready), .busy_o(busyS), .missed_o(missedS),
      .miss_cnt_o(missCntS)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] cnt,
                                input logic pce, input logic rdy);
      enable   = en;
      count    = cnt;
      periodCe = pce;
      ready    = rdy;
      step();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearExp();
      for (int k = 0; k < 8; k++) begin
         expWord[k]  = '0;
         expWordS[k] = '0;
      end
   endtask

   // Drains a full stream with ready held high, checking both instances word by word.
   task automatic runStream(input string tag);
      count    = '0;
      periodCe = 1'b0;
      ready    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("%s_valid%0d", tag, k), 32'(valid), 32'd1);
         checkOutput($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
         checkOutput($sformatf("%s_chan%0d", tag, k), 32'(chan), 32'(k));
         checkOutput($sformatf("%s_dat%0d", tag, k), 32'(dat), 32'(expWord[k]));
         checkOutput($sformatf("%s_last%0d", tag, k), 32'(last), 32'(k == 7));
         checkOutput($sformatf("%s_datS%0d", tag, k), 32'(datS), 32'(expWordS[k]));
         step();
      end
      checkOutput({tag, "_validEnd"}, 32'(valid), 32'd0);
   endtask

   initial begin
      int idx;
      rstN = 1'b0; enable = 1'b0; count = '0; periodCe = 1'b0; ready = 1'b0;
      #12;
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_dat", 32'(dat), 32'd0);
      checkOutput("rst_missCnt", 32'(missCnt), 32'd0);
      rstN = 1'b1;
      step();

      $display("[TB] basic count");
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, ((i < 5) ? 8'h01 : 8'h00) | 8'h08, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
      clearExp();
      expWord[0] = 13'h005;  expWord[3] = 13'h064;
      expWordS[0] = 5'h05;   expWordS[3] = 5'h1F;
      runStream("basic");

      $display("[TB] saturation");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, ((i < 15) ? 8'h04 : 8'h00) | 8'h02, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
      clearExp();
      expWord[1] = 13'h014;  expWord[2] = 13'h00F;
      expWordS[1] = 5'h1F;   expWordS[2] = 5'h0F;
      runStream("sat");

      $display("[TB] period boundary");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
      clearExp();
      expWord[0] = 13'h003;  expWordS[0] = 5'h03;
      runStream("bound1");
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
      clearExp();
      expWord[0] = 13'h001;  expWordS[0] = 5'h01;
      runStream("bound2");

      $display("[TB] backpressure");
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      periodCe = 1'b0;
      for (int s = 0; s < 10; s++) begin
         checkOutput("bp_stallValid", 32'(valid), 32'd1);
         checkOutput("bp_stallChan", 32'(chan), 32'd0);
         checkOutput("bp_stallDat", 32'(dat), 32'd3);
         step();
      end
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         ready = (cyc % 2 == 0);
         if (valid && ready) begin
            checkOutput("bp_chan", 32'(chan), 32'(idx));
            checkOutput("bp_dat", 32'(dat), (idx < 4) ? 32'd3 : 32'd2);
            idx++;
         end
         step();
      end
      checkOutput("bp_delivered", 32'(idx), 32'd8);
      checkOutput("bp_validEnd", 32'(valid), 32'd0);

      $display("[TB] missed snapshot");
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
      checkOutput("miss_noPulseYet", 32'(missed), 32'd0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      checkOutput("miss_pulse", 32'(missed), 32'd1);
      checkOutput("miss_cnt1", 32'(missCnt), 32'd1);
      checkOutput("miss_chanHeld", 32'(chan), 32'd0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      checkOutput("miss_pulseEnd", 32'(missed), 32'd0);
      clearExp();
      expWord[5] = 13'h007;  expWordS[5] = 5'h07;
      runStream("miss");

      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
         applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      end
      checkOutput("miss_cntSat", 32'(missCnt), 32'd255);
      clearExp();
      runStream("missDrain");

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
      periodCe = 1'b0;
      step(); step(); step();
      checkOutput("rstm_chan3", 32'(chan), 32'd3);
      #1 rstN = 1'b0;
      #1;
      checkOutput("rstm_validAsync", 32'(valid), 32'd0);
      checkOutput("rstm_busyAsync", 32'(busy), 32'd0);
      checkOutput("rstm_lastAsync", 32'(last), 32'd0);
      #20 rstN = 1'b1;
      ready = 1'b0;
      step();
      checkOutput("rstm_valid", 32'(valid), 32'd0);
      checkOutput("rstm_chan", 32'(chan), 32'd0);
      checkOutput("rstm_dat", 32'(dat), 32'd0);
      checkOutput("rstm_missCnt", 32'(missCnt), 32'd0);
      checkOutput("rstm_missed", 32'(missed), 32'd0);
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
      clearExp();
      expWord[2] = 13'h002;  expWordS[2] = 5'h02;
      runStream("rstm");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
